debounce_bank: RTL and testbench

Parametrised multi-channel switch debouncer for the board-level input path, between raw pushbutton/slide-switch pins and user logic. Each channel is synchronised, then qualified by a per-channel FSM that requires STABLE consecutive sample ticks of a constant level before changing its output. A single shared tick generator serves all channels. Each channel provides a debounced level plus one-cycle rise and fall pulses.

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_chan.sv | 90 +++++++++
 rtl/debounce_bank.sv | 49 ++++
 tb/tb_debounce_bank.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the switch debouncer bank.
// Holds the per-channel state encoding and a width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: synchroniser, qualifying FSM, edge pulses.
// db is bit 1 of the state register, so it cannot glitch.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE = 3,
    parameter int SYNC   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2(STABLE + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

    logic [SYNC-1:0] sync_q;
    logic            sw_s;
    state_t          state;
    logic [CW-1:0]   cnt;

    // Metastability chain; only the last stage feeds the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], sw};
        end
    end

    assign sw_s = sync_q[SYNC-1];

    // Level qualification; an input reversal aborts before any tick counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                ZERO: begin
                    if (sw_s) begin
                        state <= WAIT1;
                        cnt   <= '0;
                    end
                end
                WAIT1: begin
                    if (!sw_s) begin
                        state <= ZERO;
                    end else if (tick) begin
                        if (cnt == LAST) begin
                            state <= ONE;
                            rise  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ONE: begin
                    if (!sw_s) begin
                        state <= WAIT0;
                        cnt   <= '0;
                    end
                end
                WAIT0: begin
                    if (sw_s) begin
                        state <= ONE;
                    end else if (tick) begin
                        if (cnt == LAST) begin
                            state <= ZERO;
                            fall  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign db = state[1];

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer with one shared sample-tick counter.
// fast_tick forces a tick every cycle for bring-up and simulation.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CH     = 4,
    parameter int TICK_N = 19,
    parameter int STABLE = 3,
    parameter int SYNC   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fast_tick,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
);

    logic [TICK_N-1:0] q;
    logic              tick;

    // Free-running prescaler; wraps naturally at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q + 1'b1;
        end
    end

    assign tick = fast_tick | (q == '1);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        debounce_chan #(
            .STABLE (STABLE),
            .SYNC   (SYNC)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .sw    (sw[i]),
            .db    (db[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: directed scenarios plus random toggling.
// A run-of-disagreement model predicts db/rise/fall every cycle.
module tb_debounce_bank;

    localparam int CH     = 4;
    localparam int TICK_N = 4;
    localparam int STABLE = 3;
    localparam int SYNC   = 2;
    localparam int P      = 1 << TICK_N;

    logic          clk = 1'b0;
    logic          reset;
    logic          fast_tick;
    logic [CH-1:0] sw;
    logic [CH-1:0] db;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;

    debounce_bank #(
        .CH     (CH),
        .TICK_N (TICK_N),
        .STABLE (STABLE),
        .SYNC   (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fast_tick (fast_tick),
        .sw        (sw),
        .db        (db),
        .rise      (rise),
        .fall      (fall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CH-1:0] db;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } exp_t;

    exp_t sbq[$];

    int rise_cnt[CH];
    int fall_cnt[CH];
    int hi_cnt[CH];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the raw input, delayed by the synchroniser depth,
    // must disagree with db through an unbroken run of edges; ticks seen
    // after the first edge of that run are counted, STABLE of them flip db.
    logic [CH-1:0] sw_dly[SYNC];
    logic [CH-1:0] db_m;
    bit            in_run[CH];
    int            run_ticks[CH];
    int            q_m;

    always @(posedge clk) begin
        exp_t e;
        bit   tk;
        bit   lvl;
        e = '0;
        if (reset) begin
            q_m  = 0;
            db_m = '0;
            for (int i = 0; i < SYNC; i++) sw_dly[i] = '0;
            for (int c = 0; c < CH; c++) begin
                in_run[c]    = 0;
                run_ticks[c] = 0;
            end
        end else begin
            tk  = fast_tick || (q_m == P - 1);
            q_m = (q_m + 1) % P;
            for (int c = 0; c < CH; c++) begin
                lvl = sw_dly[SYNC-1][c];
                if (lvl == db_m[c]) begin
                    in_run[c] = 0;
                end else if (!in_run[c]) begin
                    in_run[c]    = 1;
                    run_ticks[c] = 0;
                end else if (tk) begin
                    run_ticks[c]++;
                    if (run_ticks[c] == STABLE) begin
                        db_m[c]   = lvl;
                        in_run[c] = 0;
                        if (lvl) e.rise[c] = 1'b1;
                        else     e.fall[c] = 1'b1;
                    end
                end
            end
            for (int i = SYNC - 1; i > 0; i--) sw_dly[i] = sw_dly[i-1];
            sw_dly[0] = sw;
        end
        e.db = db_m;
        sbq.push_back(e);
    end

    // Monitor: every cycle the DUT presents outputs, compare with the queue.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: no expected entry at %0t", $time);
        end else begin
            e = sbq.pop_front();
            chk("sb_db", 32'(db), 32'(e.db));
            chk("sb_rise", 32'(rise), 32'(e.rise));
            chk("sb_fall", 32'(fall), 32'(e.fall));
        end
        for (int c = 0; c < CH; c++) begin
            if (rise[c]) rise_cnt[c]++;
            if (fall[c]) fall_cnt[c]++;
            if (db[c])   hi_cnt[c]++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_reset(input logic v);
        @(negedge clk);
        #1;
        reset = v;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base2;
        int n;
        reset     = 1'b1;
        fast_tick = 1'b1;
        sw        = 4'hF;
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            hi_cnt[c]   = 0;
        end

        // Reset with all switches high, then release.
        repeat (3) @(negedge clk);
        #2;
        chk("rst_db", 32'(db), 32'h0);
        chk("rst_rise", 32'(rise), 32'h0);
        set_reset(1'b0);
        step(5);
        chk("s1_db_early", 32'(db), 32'h0);
        step(1);
        chk("s1_db", 32'(db), 32'hF);
        chk("s1_rise", 32'(rise), 32'hF);
        step(1);
        chk("s1_rise_once", 32'(rise), 32'h0);
        sw = 4'h0;
        step(12);
        chk("s1_fall_cnt0", 32'(fall_cnt[0]), 32'd1);
        chk("s1_db_low", 32'(db), 32'h0);

        // Short pulse on channel 0 is filtered.
        base  = rise_cnt[0];
        base2 = hi_cnt[0];
        sw[0] = 1'b1;
        step(3);
        sw[0] = 1'b0;
        step(12);
        chk("s2_rise", 32'(rise_cnt[0] - base), 32'd0);
        chk("s2_db_hi", 32'(hi_cnt[0] - base2), 32'd0);

        // Bouncing channel 1 rising, then falling.
        base = rise_cnt[1];
        for (int i = 0; i < 10; i++) begin
            sw[1] = ~sw[1];
            step(2);
        end
        sw[1] = 1'b1;
        step(5);
        chk("s3_db_early", 32'(db[1]), 32'd0);
        step(1);
        chk("s3_db", 32'(db[1]), 32'd1);
        chk("s3_rise", 32'(rise[1]), 32'd1);
        step(4);
        chk("s3_rise_cnt", 32'(rise_cnt[1] - base), 32'd1);
        base = fall_cnt[1];
        for (int i = 0; i < 10; i++) begin
            sw[1] = ~sw[1];
            step(2);
        end
        sw[1] = 1'b0;
        step(6);
        chk("s3_fall", 32'(fall[1]), 32'd1);
        step(4);
        chk("s3_fall_cnt", 32'(fall_cnt[1] - base), 32'd1);

        // Simultaneous rise on channels 0 and 2.
        sw = 4'b0101;
        step(5);
        chk("s4_rise_early", 32'(rise), 32'h0);
        step(1);
        chk("s4_rise", 32'(rise), 32'h5);
        chk("s4_db", 32'(db), 32'h5);
        sw = 4'h0;
        step(12);

        // Reset while channel 3 is qualifying a rise.
        base = fall_cnt[3];
        sw[3] = 1'b1;
        step(4);
        set_reset(1'b1);
        #1;
        chk("s5w_db", 32'(db), 32'h0);
        chk("s5w_rise", 32'(rise), 32'h0);
        repeat (2) @(negedge clk);
        set_reset(1'b0);
        step(10);
        chk("s5w_db_after", 32'(db[3]), 32'd1);
        chk("s5w_fall", 32'(fall_cnt[3] - base), 32'd0);

        // Reset while channel 3 is settled high.
        set_reset(1'b1);
        #1;
        chk("s5o_db", 32'(db), 32'h0);
        chk("s5o_fall", 32'(fall), 32'h0);
        repeat (2) @(negedge clk);
        chk("s5o_fall_cnt", 32'(fall_cnt[3] - base), 32'd0);
        set_reset(1'b0);
        step(10);
        sw = 4'h0;
        step(12);

        // Slow ticks: WAIT entry to db change across random q phases.
        fast_tick = 1'b0;
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, P - 1)) step(1);
            sw[3] = 1'b1;
            step(3);
            n = 0;
            while (!db[3] && n < 60) begin
                step(1);
                n++;
            end
            checks++;
            if (n < (STABLE - 1) * P + 1 || n > STABLE * P) begin
                errors++;
                $display("FAIL s6_rise_lat: got %0d cycles expected %0d..%0d",
                         n, (STABLE - 1) * P + 1, STABLE * P);
            end
            repeat ($urandom_range(0, P - 1)) step(1);
            sw[3] = 1'b0;
            step(3);
            n = 0;
            while (db[3] && n < 60) begin
                step(1);
                n++;
            end
            checks++;
            if (n < (STABLE - 1) * P + 1 || n > STABLE * P) begin
                errors++;
                $display("FAIL s6_fall_lat: got %0d cycles expected %0d..%0d",
                         n, (STABLE - 1) * P + 1, STABLE * P);
            end
        end

        // Random toggling, tick-mode changes and occasional resets.
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 19) == 0) fast_tick = ~fast_tick;
            if ($urandom_range(0, 39) == 0) begin
                set_reset(1'b1);
                step(1);
                set_reset(1'b0);
            end
            sw = sw ^ CH'($urandom);
            step($urandom_range(1, fast_tick ? 8 : 60));
        end

        step(5);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
